// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, frame geometry, parity sense.
// Pure declarations, no logic.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  // 0 selects even parity (XOR over data and parity bit must be 0).
  localparam bit UART_PARITY_ODD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser with configurable width and reset value; 2 clk_100m cycles latency.
// No flow control: samples every cycle.
module uart_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 with UART_RX_PARITY_EN); byte valid one cycle after the mid-stop tick.
// No backpressure: sticky rdy, a new byte overwrites data and flags overrun if rdy is still set.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 overrun,
  output logic                 parity_err
`else
  output logic                 overrun
`endif
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_s;
  rx_state_t            state, state_nxt;
  logic [SW-1:0]        smp, smp_nxt;
  logic [BW-1:0]        bit_idx, bit_idx_nxt;
  logic                 mid;
  logic                 shift_en, stop_en;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 par_en;
  logic                 par_bit;
`endif

  uart_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .d        (rx),
    .q        (rx_s)
  );

  assign mid = (smp == SW'(OVERSAMPLE - 1));

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state   <= IDLE;
      smp     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      smp     <= smp_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    smp_nxt     = smp;
    bit_idx_nxt = bit_idx;
    shift_en    = 1'b0;
    stop_en     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en      = 1'b0;
`endif
    if (rxclk_en) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            smp_nxt   = '0;
            state_nxt = START;
          end
        end
        START: begin
          smp_nxt = smp + 1'b1;
          // Half a bit in: a low line here confirms a real start bit.
          if (smp == SW'(OVERSAMPLE / 2 - 1)) begin
            if (!rx_s) begin
              smp_nxt     = '0;
              bit_idx_nxt = '0;
              state_nxt   = DATA;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DATA: begin
          smp_nxt = smp + 1'b1;
          if (mid) begin
            shift_en    = 1'b1;
            bit_idx_nxt = bit_idx + 1'b1;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          smp_nxt = smp + 1'b1;
          if (mid) begin
            par_en    = 1'b1;
            state_nxt = STOP;
          end
        end
`endif
        STOP: begin
          smp_nxt = smp + 1'b1;
          // Leaving at mid-stop lets the next start edge be caught with no idle gap.
          if (mid) begin
            stop_en   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      shreg      <= '0;
      data       <= '0;
      rdy        <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
      if (par_en) par_bit <= rx_s;
`endif
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      // Good stop wins over a coincident rdy_clr; that clear also suppresses overrun.
      if (stop_en) begin
        if (rx_s) begin
          data      <= shreg;
          rdy       <= 1'b1;
          frame_err <= 1'b0;
          if (rdy && !rdy_clr) overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= (^shreg) ^ par_bit ^ UART_PARITY_ODD;
`endif
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: one rxclk_en tick every 4 clk_100m cycles.
module tb_uart_rx;

  localparam int TICK_DIV = 4;

  logic       clk_100m = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rxclk_en = 1'b0;
  logic       rx       = 1'b1;
  logic       rdy_clr  = 1'b0;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int   checks = 0;
  int   errors = 0;
  logic rdy_early;

  uart_rx dut (
    .clk_100m   (clk_100m),
    .rst_n      (rst_n),
    .rxclk_en   (rxclk_en),
    .rx         (rx),
    .rdy_clr    (rdy_clr),
    .data       (data),
    .rdy        (rdy),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .overrun    (overrun),
    .parity_err (parity_err)
`else
    .overrun    (overrun)
`endif
  );

  initial forever #5 clk_100m = ~clk_100m;

  // Tick changes on the falling edge so it is stable at every rising edge.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk_100m);
      rxclk_en = (cnt == 0);
      cnt = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns just after the rising edge of the n-th following tick.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk_100m);
      while (!rxclk_en) @(posedge clk_100m);
    end
  endtask

  task automatic drive_bit(input logic v);
    #1 rx = v;
    wait_ticks(16);
  endtask

  task automatic pulse_clr();
    @(negedge clk_100m);
    rdy_clr = 1'b1;
    @(negedge clk_100m);
    rdy_clr = 1'b0;
  endtask

  // Full frame; rdy_early samples rdy a few ticks into the stop bit, before its mid-point.
  // clr_at_stop raises rdy_clr in exactly the cycle the DUT samples the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input int gap, input logic clr_at_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    #1 rx = stop_bit;
    wait_ticks(4);
    #1 rdy_early = rdy;
    wait_ticks(4);
    if (clr_at_stop) begin
      repeat (3) @(posedge clk_100m);
      @(negedge clk_100m);
      rdy_clr = 1'b1;
      @(negedge clk_100m);
      rdy_clr = 1'b0;
      wait_ticks(7);
    end else begin
      wait_ticks(8);
    end
    #1 rx = 1'b1;
    wait_ticks(gap);
    @(negedge clk_100m);
  endtask

  initial begin
    repeat (5) @(negedge clk_100m);
    chk("reset_rdy", rdy, 0);
    chk("reset_data", data, 8'h00);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    wait_ticks(2);

    send_frame(8'hA5, 1'b1, 1'b0, 2, 1'b0);
    chk("a5_rdy_before_mid_stop", rdy_early, 0);
    chk("a5_data", data, 8'hA5);
    chk("a5_rdy", rdy, 1);
    chk("a5_frame_err", frame_err, 0);
    chk("a5_overrun", overrun, 0);
`ifdef UART_RX_PARITY_EN
    chk("a5_parity_err", parity_err, 0);
`endif
    pulse_clr();
    chk("clr_rdy", rdy, 0);

    // False start: 4 ticks low then back high.
    #1 rx = 1'b0;
    wait_ticks(4);
    #1 rx = 1'b1;
    wait_ticks(30);
    @(negedge clk_100m);
    chk("false_start_rdy", rdy, 0);
    chk("false_start_data", data, 8'hA5);

    // Low stop bit; long gap lets the spurious start it causes be rejected.
    send_frame(8'h3C, 1'b0, 1'b0, 20, 1'b0);
    chk("badstop_frame_err", frame_err, 1);
    chk("badstop_rdy", rdy, 0);
    chk("badstop_data", data, 8'hA5);

    send_frame(8'h11, 1'b1, 1'b0, 2, 1'b0);
    chk("11_data", data, 8'h11);
    chk("11_rdy", rdy, 1);
    chk("11_frame_err", frame_err, 0);
    pulse_clr();

    send_frame(8'h01, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b0, 2, 1'b0);
    chk("b2b_data", data, 8'hFE);
    chk("b2b_rdy", rdy, 1);
    chk("b2b_overrun", overrun, 1);
    pulse_clr();
    chk("b2b_clr_rdy", rdy, 0);
    chk("b2b_clr_overrun", overrun, 0);

    // rdy already set, then rdy_clr lands on the completing stop sample.
    send_frame(8'h42, 1'b1, 1'b0, 2, 1'b0);
    send_frame(8'h99, 1'b1, 1'b0, 2, 1'b1);
    chk("coinc_data", data, 8'h99);
    chk("coinc_rdy", rdy, 1);
    chk("coinc_overrun", overrun, 0);

    // Reset during bit 3 of 0x5A.
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #1 rx = 1'b1;
    wait_ticks(8);
    @(negedge clk_100m);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100m);
    rst_n = 1'b1;
    wait_ticks(30);
    @(negedge clk_100m);
    chk("rst_abort_rdy", rdy, 0);
    chk("rst_abort_data", data, 8'h00);
    wait_ticks(1);
    send_frame(8'hC3, 1'b1, 1'b0, 2, 1'b0);
    chk("c3_data", data, 8'hC3);
    chk("c3_rdy", rdy, 1);
    chk("c3_overrun", overrun, 0);

`ifdef UART_RX_PARITY_EN
    pulse_clr();
    wait_ticks(1);
    send_frame(8'h07, 1'b1, 1'b1, 2, 1'b0);
    chk("par07_data", data, 8'h07);
    chk("par07_parity_err", parity_err, 1);
    send_frame(8'h07, 1'b1, 1'b0, 2, 1'b0);
    chk("par07_good_parity_err", parity_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
